// File: rtl/captura_jogada.sv
// captura_jogada: synchronises and debounces 4 raw buttons, registers a one-hot move with a 1-cycle strobe.
// Optional idle timeout is built only when TIMEOUT_JOGADA_EN is defined; otherwise timeout is tied 0.
module captura_jogada #(
    parameter int DEBOUNCE_CICLOS = 4,
    parameter int CONT_W          = 8,
    parameter int TIMEOUT_CICLOS  = 200
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] botoes,
    input  logic       enable,
    input  logic       limpa,
    output logic [3:0] jogada,
    output logic       jogada_valida,
    output logic       erro_multiplo,
    output logic       ocupado,
    output logic       timeout
);

    // state         | meaning
    // OCIOSO        | idle, waiting for any synchronised press while enabled
    // ESTAVEL       | candidate press seen, counting stable samples
    // REGISTRA      | debounce done; store move or flag multiple press
    // ESPERA_SOLTAR | waiting for all buttons released before re-arming
    typedef enum logic [1:0] {
        OCIOSO        = 2'd0,
        ESTAVEL       = 2'd1,
        REGISTRA      = 2'd2,
        ESPERA_SOLTAR = 2'd3
    } estado_t;

    localparam logic [CONT_W-1:0] DEB_MAX = CONT_W'(DEBOUNCE_CICLOS - 1);

    if (DEBOUNCE_CICLOS < 1 || DEBOUNCE_CICLOS > 2**CONT_W ||
        TIMEOUT_CICLOS < 1 || TIMEOUT_CICLOS > 2**CONT_W) begin : g_param_check
        $error("captura_jogada: DEBOUNCE_CICLOS/TIMEOUT_CICLOS do not fit in CONT_W");
    end

    estado_t           state_q, state_d;
    logic [3:0]        sync1_q, sync1_d;
    logic [3:0]        s_q, s_d;
    logic [3:0]        cand_q, cand_d;
    logic [CONT_W-1:0] cnt_q, cnt_d;
    logic [3:0]        jogada_q, jogada_d;
    logic              valida_q, valida_d;
    logic              erro_q, erro_d;
    logic              cand_um_bit;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= OCIOSO;
            sync1_q  <= '0;
            s_q      <= '0;
            cand_q   <= '0;
            cnt_q    <= '0;
            jogada_q <= '0;
            valida_q <= 1'b0;
            erro_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync1_q  <= sync1_d;
            s_q      <= s_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            jogada_q <= jogada_d;
            valida_q <= valida_d;
            erro_q   <= erro_d;
        end
    end

    always_comb begin
        sync1_d = botoes;
        s_d     = sync1_q;
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        if (limpa) begin
            state_d = OCIOSO;
            cand_d  = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                OCIOSO: begin
                    if (enable && s_q != 4'd0) begin
                        state_d = ESTAVEL;
                        cand_d  = s_q;
                        cnt_d   = '0;
                    end
                end
                ESTAVEL: begin
                    if (!enable) begin
                        state_d = OCIOSO;
                    end else if (s_q != cand_q) begin
                        // a different non-zero pattern restarts debounce on the new candidate
                        if (s_q == 4'd0) begin
                            state_d = OCIOSO;
                        end else begin
                            cand_d = s_q;
                            cnt_d  = '0;
                        end
                    end else if (cnt_q == DEB_MAX) begin
                        state_d = REGISTRA;
                    end else begin
                        cnt_d = cnt_q + CONT_W'(1);
                    end
                end
                REGISTRA: begin
                    state_d = ESPERA_SOLTAR;
                end
                ESPERA_SOLTAR: begin
                    if (s_q == 4'd0) state_d = OCIOSO;
                end
                default: begin
                    state_d = OCIOSO;
                end
            endcase
        end
    end

    always_comb begin
        cand_um_bit = (cand_q != 4'd0) && ((cand_q & (cand_q - 4'd1)) == 4'd0);
        jogada_d    = jogada_q;
        valida_d    = 1'b0;
        erro_d      = 1'b0;
        if (limpa) begin
            jogada_d = '0;
        end else if (state_q == REGISTRA) begin
            if (cand_um_bit) begin
                jogada_d = cand_q;
                valida_d = 1'b1;
            end else begin
                erro_d = 1'b1;
            end
        end
    end

`ifdef TIMEOUT_JOGADA_EN
    localparam logic [CONT_W-1:0] TMO_MAX = CONT_W'(TIMEOUT_CICLOS - 1);

    logic [CONT_W-1:0] tmo_q, tmo_d;
    logic              timeout_q, timeout_d;
    logic              tmo_conta;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tmo_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_q     <= tmo_d;
            timeout_q <= timeout_d;
        end
    end

    // a press leaving OCIOSO on the same edge takes precedence over the timeout
    always_comb begin
        tmo_conta = !limpa && (state_q == OCIOSO) && enable && (s_q == 4'd0);
        timeout_d = tmo_conta && (tmo_q == TMO_MAX);
        tmo_d     = '0;
        if (tmo_conta && !timeout_d) tmo_d = tmo_q + CONT_W'(1);
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign jogada        = jogada_q;
    assign jogada_valida = valida_q;
    assign erro_multiplo = erro_q;
    assign ocupado       = (state_q != OCIOSO);

endmodule
